// File: rtl/magia_pkg.sv
// AXI4 channel and bundle types shared by the MAGIA tile and its memory models.
// 32-bit address and data, 4-bit IDs.
package magia_pkg;

  localparam int unsigned AXI_AW = 32;
  localparam int unsigned AXI_DW = 32;
  localparam int unsigned AXI_IW = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [5:0]        atop;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_default_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_default_rsp_t;

endpackage

// File: rtl/magia_axi_mem_responder.sv
// AXI4 subordinate backed by a flat word memory: one write and one read burst in flight,
// byte strobes, FIXED/INCR/WRAP addressing and SLVERR for range or protocol violations.
module magia_axi_mem_responder #(
  parameter int unsigned N_WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          ERR_ON_WRAP = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  magia_pkg::axi_default_req_t axi_req_i,
  output magia_pkg::axi_default_rsp_t axi_rsp_o
);
  import magia_pkg::*;

  // Every channel moves a beat only on a cycle where its valid and ready are both 1 at the
  // rising clock edge; valid, once raised, holds its payload stable until that handshake.
  localparam int unsigned DW    = AXI_DW;
  localparam int unsigned BPW   = DW / 8;
  localparam int unsigned OFF_W = $clog2(BPW);
  localparam int unsigned IDX_W = $clog2(N_WORDS);
  localparam logic [32:0] SPAN  = 33'(N_WORDS * BPW);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [7:0] beat);
    logic [31:0] off;
    logic [31:0] mask;
    off  = {24'd0, beat} << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: beat_addr = addr;
      BURST_WRAP:  beat_addr = (addr & ~mask) | ((addr + off) & mask);
      default:     beat_addr = addr + off;
    endcase
  endfunction

  // A borrow out of the 33-bit subtraction flags addresses below the base.
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] rel;
    rel = {1'b0, a} - {1'b0, BASE_ADDR};
    return !rel[32] && (rel < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [DW-1:0] mem_q [N_WORDS];

  // ---------------- write path ----------------
  logic [1:0]        w_state_q, w_state_d;
  logic [AXI_IW-1:0] aw_id_q, aw_id_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic [7:0]        w_beat_q, w_beat_d;
  logic              w_err_q, w_err_d;
  logic              w_sup_q, w_sup_d;
  logic              aw_ready_q, aw_ready_d;
  logic              w_ready_q, w_ready_d;
  logic              b_valid_q, b_valid_d;
  logic [31:0]       wb_addr;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_err_d    = w_err_q;
    w_sup_d    = w_sup_q;
    mem_we     = 1'b0;
    wb_addr    = beat_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q, w_beat_q);
    mem_widx   = word_idx(wb_addr);
    case (w_state_q)
      W_IDLE: begin
        if (axi_req_i.aw_valid && aw_ready_q) begin
          aw_id_d    = axi_req_i.aw.id;
          aw_addr_d  = axi_req_i.aw.addr;
          aw_len_d   = axi_req_i.aw.len;
          aw_size_d  = axi_req_i.aw.size;
          aw_burst_d = axi_req_i.aw.burst;
          w_beat_d   = 8'd0;
          // Atomics and (optionally) WRAP are refused for the whole burst.
          w_sup_d    = (axi_req_i.aw.atop != 6'd0) ||
                       (ERR_ON_WRAP && (axi_req_i.aw.burst == BURST_WRAP));
          w_err_d    = w_sup_d;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_req_i.w_valid && w_ready_q) begin
          if (!in_range(wb_addr)) w_err_d = 1'b1;
          else if (!w_sup_q)      mem_we  = 1'b1;
          if (w_beat_q == aw_len_q) begin
            w_state_d = W_RESP;
            if (!axi_req_i.w.last) w_err_d = 1'b1;
          end else if (axi_req_i.w.last) begin
            w_state_d = W_RESP;
            w_err_d   = 1'b1;
          end else begin
            w_beat_d = w_beat_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (axi_req_i.b_ready && b_valid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
      w_sup_q    <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_err_q    <= w_err_d;
      w_sup_q    <= w_sup_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
    end
  end

  // Contents survive reset; a read in the same cycle sees the old word.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BPW); b++) begin
        if (axi_req_i.w.strb[b]) mem_q[mem_widx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]        r_state_q, r_state_d;
  logic [AXI_IW-1:0] ar_id_q, ar_id_d;
  logic [31:0]       ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [1:0]        ar_burst_q, ar_burst_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic              ar_ready_q, ar_ready_d;
  logic              r_valid_q, r_valid_d;
  logic [DW-1:0]     r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              r_last_q, r_last_d;
  logic              rd_load;
  logic [7:0]        rd_beat;
  logic [7:0]        rd_len;
  logic [1:0]        rd_burst;
  logic [31:0]       rd_addr;

  // The output register always holds the beat on offer; the next beat is fetched on the
  // handshake edge so a continuously ready manager sees one beat per cycle.
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    rd_load    = 1'b0;
    rd_beat    = r_beat_q + 8'd1;
    rd_len     = ar_len_q;
    rd_burst   = ar_burst_q;
    rd_addr    = beat_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q, rd_beat);
    if (r_state_q == R_IDLE) begin
      if (axi_req_i.ar_valid && ar_ready_q) begin
        ar_id_d    = axi_req_i.ar.id;
        ar_addr_d  = axi_req_i.ar.addr;
        ar_len_d   = axi_req_i.ar.len;
        ar_size_d  = axi_req_i.ar.size;
        ar_burst_d = axi_req_i.ar.burst;
        r_beat_d   = 8'd0;
        rd_beat    = 8'd0;
        rd_len     = axi_req_i.ar.len;
        rd_burst   = axi_req_i.ar.burst;
        rd_addr    = beat_addr(axi_req_i.ar.addr, axi_req_i.ar.len, axi_req_i.ar.size,
                               axi_req_i.ar.burst, 8'd0);
        rd_load    = 1'b1;
        r_state_d  = R_DATA;
      end
    end else begin
      if (axi_req_i.r_ready && r_valid_q) begin
        if (r_last_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_beat_d = rd_beat;
          rd_load  = 1'b1;
        end
      end
    end
    if (rd_load) begin
      r_last_d = (rd_beat == rd_len);
      if (!in_range(rd_addr) || (ERR_ON_WRAP && (rd_burst == BURST_WRAP))) begin
        r_data_d = '0;
        r_resp_d = RESP_SLVERR;
      end else begin
        r_data_d = mem_q[word_idx(rd_addr)];
        r_resp_d = RESP_OKAY;
      end
    end
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready_q;
    axi_rsp_o.w_ready  = w_ready_q;
    axi_rsp_o.b_valid  = b_valid_q;
    axi_rsp_o.b.id     = aw_id_q;
    axi_rsp_o.b.resp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
    axi_rsp_o.ar_ready = ar_ready_q;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r.id     = ar_id_q;
    axi_rsp_o.r.data   = r_data_q;
    axi_rsp_o.r.resp   = r_resp_q;
    axi_rsp_o.r.last   = r_last_q;
  end

endmodule

// File: tb/tb_magia_axi_mem_responder.sv
// Directed bench for magia_axi_mem_responder: 64-word memory at 0x1000_0000, 32-bit data.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_magia_axi_mem_responder;
  import magia_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned NW   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_default_req_t req;
  axi_default_rsp_t rsp;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] wdata [16];
  logic [3:0]  wstrb [16];
  logic [31:0] rdata [16];
  logic [1:0]  rresp [16];
  logic        rlast [16];
  logic [3:0]  rid   [16];
  int          rcount;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  always #5 clk = ~clk;

  magia_axi_mem_responder #(
    .N_WORDS    (NW),
    .BASE_ADDR  (BASE),
    .ERR_ON_WRAP(1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi_req_i(req),
    .axi_rsp_o(rsp)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // last_at: index of the beat that carries w.last (-1: never asserted)
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] atop, input int n_beats, input int last_at,
                          input logic [3:0] id);
    int cnt;
    logic to;
    to = 1'b0;
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw.size  = 3'd2;
    req.aw.burst = burst;
    req.aw.atop  = atop;
    req.aw_valid = 1'b1;
    cnt = 0;
    while (!rsp.aw_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) to = 1'b1;
    @(negedge clk);
    req.aw_valid = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      req.w.data  = wdata[i];
      req.w.strb  = wstrb[i];
      req.w.last  = (i == last_at);
      req.w_valid = 1'b1;
      cnt = 0;
      while (!rsp.w_ready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) to = 1'b1;
      @(negedge clk);
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    req.b_ready = 1'b1;
    cnt = 0;
    while (!rsp.b_valid && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) to = 1'b1;
    bresp = rsp.b.resp;
    bid   = rsp.b.id;
    @(negedge clk);
    req.b_ready = 1'b0;
    check("wr_timeout", to, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle);
    int cnt;
    int cyc;
    bit stall;
    logic [63:0] hv;
    req.ar       = '0;
    req.ar.id    = id;
    req.ar.addr  = addr;
    req.ar.len   = len;
    req.ar.size  = 3'd2;
    req.ar.burst = burst;
    req.ar_valid = 1'b1;
    cnt = 0;
    while (!rsp.ar_ready && cnt < 50) begin @(negedge clk); cnt++; end
    check("ar_timeout", (cnt >= 50), 1'b0);
    @(negedge clk);
    req.ar_valid = 1'b0;
    check("r_latency", rsp.r_valid, 1'b1);
    rcount = 0;
    cyc    = 0;
    stall  = 1'b0;
    hv     = '0;
    while (rcount < int'(len) + 1 && cyc < 200) begin
      req.r_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rsp.r_valid && req.r_ready) begin
        rdata[rcount] = rsp.r.data;
        rresp[rcount] = rsp.r.resp;
        rlast[rcount] = rsp.r.last;
        rid[rcount]   = rsp.r.id;
        rcount++;
      end else if (rsp.r_valid) begin
        stall = 1'b1;
        hv    = 64'({rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last});
      end
      @(negedge clk);
      cyc++;
      if (stall) begin
        check("r_stable", 64'({rsp.r_valid, rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last}),
              hv | (64'd1 << 39));
        stall = 1'b0;
      end
    end
    req.r_ready = 1'b0;
    check("rd_beats", rcount, int'(len) + 1);
    check("r_done", rsp.r_valid, 1'b0);
  endtask

  initial begin
    int cnt;
    req = '0;
    for (int i = 0; i < 16; i++) wstrb[i] = 4'hF;

    // Reset behaviour and the first registered ready.
    repeat (3) @(negedge clk);
    check("rst_aw_ready", rsp.aw_ready, 1'b0);
    check("rst_ar_ready", rsp.ar_ready, 1'b0);
    check("rst_w_ready", rsp.w_ready, 1'b0);
    check("rst_b_valid", rsp.b_valid, 1'b0);
    check("rst_r_valid", rsp.r_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    check("aw_ready_before_edge", rsp.aw_ready, 1'b0);
    @(negedge clk);
    check("aw_ready_after_edge", rsp.aw_ready, 1'b1);
    check("ar_ready_after_edge", rsp.ar_ready, 1'b1);
    check("w_ready_idle", rsp.w_ready, 1'b0);

    // Single write then read.
    wdata[0] = 32'hDEAD_BEEF;
    do_write(BASE + 32'h10, 8'd0, BURST_INCR, 6'd0, 1, 0, 4'd3);
    check("single_bresp", bresp, RESP_OKAY);
    check("single_bid", bid, 4'd3);
    do_read(BASE + 32'h10, 8'd0, BURST_INCR, 4'd5, 1'b0);
    check("single_rdata", rdata[0], 32'hDEAD_BEEF);
    check("single_rresp", rresp[0], RESP_OKAY);
    check("single_rlast", rlast[0], 1'b1);
    check("single_rid", rid[0], 4'd5);

    // INCR burst of four, read back with r_ready toggling.
    for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
    do_write(BASE + 32'h20, 8'd3, BURST_INCR, 6'd0, 4, 3, 4'd1);
    check("incr_bresp", bresp, RESP_OKAY);
    do_read(BASE + 32'h20, 8'd3, BURST_INCR, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rdata[i], 32'(i + 1));
      check("incr_rlast", rlast[i], (i == 3));
      check("incr_rresp", rresp[i], RESP_OKAY);
    end

    // Partial strobe.
    wdata[0] = 32'hFFFF_FFFF;
    do_write(BASE + 32'h40, 8'd0, BURST_INCR, 6'd0, 1, 0, 4'd0);
    wdata[0] = 32'h0000_0000;
    wstrb[0] = 4'b0101;
    do_write(BASE + 32'h40, 8'd0, BURST_INCR, 6'd0, 1, 0, 4'd0);
    wstrb[0] = 4'hF;
    do_read(BASE + 32'h40, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("strb_rdata", rdata[0], 32'hFF00_FF00);

    // Out of range: one past the end must not alias onto word 0.
    wdata[0] = 32'hA5A5_0001;
    wdata[1] = 32'hA5A5_0002;
    do_write(BASE, 8'd1, BURST_INCR, 6'd0, 2, 1, 4'd0);
    check("w0_bresp", bresp, RESP_OKAY);
    wdata[0] = 32'h11;
    wdata[1] = 32'h22;
    do_write(BASE + NW * 4, 8'd1, BURST_INCR, 6'd0, 2, 1, 4'd0);
    check("oor_bresp", bresp, RESP_SLVERR);
    do_read(BASE, 8'd1, BURST_INCR, 4'd0, 1'b0);
    check("oor_w0_intact", rdata[0], 32'hA5A5_0001);
    check("oor_w1_intact", rdata[1], 32'hA5A5_0002);
    do_read(BASE + NW * 4, 8'd1, BURST_INCR, 4'd0, 1'b0);
    check("oor_rdata0", rdata[0], 32'h0);
    check("oor_rresp0", rresp[0], RESP_SLVERR);
    check("oor_rlast0", rlast[0], 1'b0);
    check("oor_rdata1", rdata[1], 32'h0);
    check("oor_rresp1", rresp[1], RESP_SLVERR);
    check("oor_rlast1", rlast[1], 1'b1);

    // Burst straddling the top: first beat lands, second is dropped.
    wdata[0] = 32'hC0DE_0001;
    wdata[1] = 32'hC0DE_0002;
    do_write(BASE + NW * 4 - 4, 8'd1, BURST_INCR, 6'd0, 2, 1, 4'd0);
    check("straddle_bresp", bresp, RESP_SLVERR);
    do_read(BASE + NW * 4 - 4, 8'd1, BURST_INCR, 4'd0, 1'b0);
    check("straddle_rdata0", rdata[0], 32'hC0DE_0001);
    check("straddle_rresp0", rresp[0], RESP_OKAY);
    check("straddle_rdata1", rdata[1], 32'h0);
    check("straddle_rresp1", rresp[1], RESP_SLVERR);
    do_read(BASE - 4, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("below_base_rresp", rresp[0], RESP_SLVERR);
    check("below_base_rdata", rdata[0], 32'h0);

    // Early w.last on beat 1 of a len=3 burst.
    for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 5);
    do_write(BASE + 32'h60, 8'd3, BURST_INCR, 6'd0, 2, 1, 4'd0);
    check("early_last_bresp", bresp, RESP_SLVERR);
    do_read(BASE + 32'h60, 8'd1, BURST_INCR, 4'd0, 1'b0);
    check("early_last_rdata0", rdata[0], 32'h5);
    check("early_last_rdata1", rdata[1], 32'h6);

    // Missing w.last on the final beat.
    wdata[0] = 32'h9;
    wdata[1] = 32'hA;
    do_write(BASE + 32'h68, 8'd1, BURST_INCR, 6'd0, 2, -1, 4'd0);
    check("no_last_bresp", bresp, RESP_SLVERR);

    // WRAP is refused on both channels.
    wdata[0] = 32'h99;
    wdata[1] = 32'h98;
    do_write(BASE + 32'h20, 8'd1, BURST_WRAP, 6'd0, 2, 1, 4'd0);
    check("wrap_bresp", bresp, RESP_SLVERR);
    do_read(BASE + 32'h20, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("wrap_no_write", rdata[0], 32'h1);
    do_read(BASE + 32'h20, 8'd1, BURST_WRAP, 4'd0, 1'b0);
    check("wrap_rresp0", rresp[0], RESP_SLVERR);
    check("wrap_rdata0", rdata[0], 32'h0);
    check("wrap_rresp1", rresp[1], RESP_SLVERR);

    // Atomic operation.
    wdata[0] = 32'h77;
    do_write(BASE + 32'h24, 8'd0, BURST_INCR, 6'h20, 1, 0, 4'd0);
    check("atop_bresp", bresp, RESP_SLVERR);
    do_read(BASE + 32'h24, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("atop_no_write", rdata[0], 32'h2);

    // FIXED burst keeps hitting one word.
    wdata[0] = 32'hA;
    wdata[1] = 32'hB;
    do_write(BASE + 32'h80, 8'd1, BURST_FIXED, 6'd0, 2, 1, 4'd0);
    check("fixed_bresp", bresp, RESP_OKAY);
    do_read(BASE + 32'h80, 8'd1, BURST_FIXED, 4'd0, 1'b0);
    check("fixed_rdata0", rdata[0], 32'hB);
    check("fixed_rdata1", rdata[1], 32'hB);

    // Same-edge write and read of one word: read returns the old value.
    wdata[0] = 32'h1111;
    do_write(BASE + 32'h30, 8'd0, BURST_INCR, 6'd0, 1, 0, 4'd0);
    req.aw       = '0;
    req.aw.addr  = BASE + 32'h30;
    req.aw.size  = 3'd2;
    req.aw.burst = BURST_INCR;
    req.aw.id    = 4'd1;
    req.aw_valid = 1'b1;
    cnt = 0;
    while (!rsp.aw_ready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w.data   = 32'h2222;
    req.w.strb   = 4'hF;
    req.w.last   = 1'b1;
    req.w_valid  = 1'b1;
    req.ar       = '0;
    req.ar.addr  = BASE + 32'h30;
    req.ar.size  = 3'd2;
    req.ar.burst = BURST_INCR;
    req.ar.id    = 4'd2;
    req.ar_valid = 1'b1;
    check("coll_w_ready", rsp.w_ready, 1'b1);
    check("coll_ar_ready", rsp.ar_ready, 1'b1);
    @(negedge clk);
    req.w_valid  = 1'b0;
    req.w.last   = 1'b0;
    req.ar_valid = 1'b0;
    check("coll_r_valid", rsp.r_valid, 1'b1);
    check("coll_old_data", rsp.r.data, 32'h1111);
    check("coll_b_valid", rsp.b_valid, 1'b1);
    check("coll_bresp", rsp.b.resp, RESP_OKAY);
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    @(negedge clk);
    req.r_ready = 1'b0;
    req.b_ready = 1'b0;
    do_read(BASE + 32'h30, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("coll_new_data", rdata[0], 32'h2222);

    // Reset during beat 1 of a len=3 read.
    req.ar       = '0;
    req.ar.addr  = BASE + 32'h20;
    req.ar.len   = 8'd3;
    req.ar.size  = 3'd2;
    req.ar.burst = BURST_INCR;
    req.ar_valid = 1'b1;
    cnt = 0;
    while (!rsp.ar_ready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    check("rst_mid_beat0", rsp.r.data, 32'h1);
    @(negedge clk);
    req.r_ready  = 1'b0;
    check("rst_mid_beat1", rsp.r.data, 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_r_valid", rsp.r_valid, 1'b0);
    check("rst_mid_ar_ready", rsp.ar_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ar_ready", rsp.ar_ready, 1'b1);
    check("rst_rel_r_valid", rsp.r_valid, 1'b0);
    do_read(BASE + 32'h20, 8'd3, BURST_INCR, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) check("rst_mem_intact", rdata[i], 32'(i + 1));
    do_read(BASE + 32'h10, 8'd0, BURST_INCR, 4'd0, 1'b0);
    check("rst_mem_single", rdata[0], 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/magia_axi_mem_responder.md
MAGIA_AXI_MEM_RESPONDER -- requirements
Module: magia_axi_mem_responder

Interface
REQ-001 SHALL have parameter N_WORDS, default 4096: number of DW-bit memory words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have parameter ERR_ON_WRAP, default 1: WRAP bursts are answered with SLVERR and have no memory effect.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port axi_req_i, input, magia_pkg::axi_default_req_t: AXI4 manager request (AW/W/AR channels, b_ready, r_ready), i.e. the tile's data_out_req.
REQ-007 SHALL have port axi_rsp_o, output, magia_pkg::axi_default_rsp_t: AXI4 subordinate response (aw/w/ar_ready, B and R channels).
REQ-008 SHALL define DW as the magia_pkg AXI data width and BPW = DW/8.

Function
REQ-009 SHALL implement a write FSM with states W_IDLE, W_DATA and W_RESP, and an independent read FSM with states R_IDLE and R_DATA.
REQ-010 SHALL assert aw_ready only in W_IDLE; on AW handshake it SHALL capture id, addr, len, size, burst and atop, clear the beat counter and the error flag, and move to W_DATA.
REQ-011 SHALL assert w_ready only in W_DATA; each W handshake SHALL write the bytes enabled by w.strb into the addressed word in the same cycle.
REQ-012 SHALL compute the beat address as: INCR = addr + beat*2^size; FIXED = addr; word index = (beat_addr - BASE_ADDR) >> log2(BPW).
REQ-013 SHALL treat a beat as out of range if beat_addr < BASE_ADDR or beat_addr >= BASE_ADDR + N_WORDS*BPW; an out-of-range beat SHALL be dropped and SHALL set the error flag.
REQ-014 SHALL set the error flag and suppress every memory write of the burst if atop != 0, or if burst == WRAP while ERR_ON_WRAP = 1.
REQ-015 SHALL leave W_DATA after beat len (counter == len), regardless of w.last; w.last on an earlier beat SHALL end the burst and set the error flag; a missing w.last on beat len SHALL set the error flag.
REQ-016 In W_RESP, SHALL hold b_valid = 1, b.id = captured id and b.resp = SLVERR if the error flag is set, else OKAY, until b_ready, then go to W_IDLE.
REQ-017 SHALL assert ar_ready only in R_IDLE; on AR handshake it SHALL capture the AR fields and move to R_DATA.
REQ-018 SHALL read memory through a registered read port: r_valid rises on the cycle after the AR handshake (1-cycle latency), and each following beat is valid on the cycle after the previous R handshake, or back-to-back when the next word is prefetched.
REQ-019 SHALL keep r.data, r.resp, r.last and r.id stable while r_valid = 1 and r_ready = 0.
REQ-020 SHALL set r.last = 1 only on beat len; r.resp = SLVERR with r.data = 0 for an out-of-range beat, or for every beat of a WRAP burst when ERR_ON_WRAP = 1; otherwise OKAY.
REQ-021 SHALL return to R_IDLE on the R handshake of the last beat.
REQ-022 On a same-cycle write and read of the same word, SHALL return the pre-write data on the read and commit the write.
REQ-023 SHALL allow one outstanding write and one outstanding read concurrently, with no ordering between them.

Reset
REQ-024 While rst_ni = 0, SHALL hold all valid and ready outputs at 0, both FSMs in their idle state, counters at 0 and the error flag clear.
REQ-025 SHALL register the ready outputs: aw_ready and ar_ready SHALL first be 1 on the first clock edge after rst_ni deasserts.
REQ-026 Reset asserted mid-burst SHALL abandon the burst with no B or R response; memory contents SHALL NOT be reset.

Verification
REQ-027 Single write then read: AW addr=BASE+0x10, len=0, W data=0xDEADBEEF, strb all ones -> B OKAY; AR to the same address -> one R beat 0xDEADBEEF, last=1, OKAY, r_valid 1 cycle after AR handshake.
REQ-028 INCR burst: AW len=3, size=log2(BPW), 4 beats 1..4 -> B OKAY after 4 beats; AR len=3 -> data 1,2,3,4 in order with last only on beat 3, correct with r_ready toggling every cycle.
REQ-029 Partial strobe: write 0xFFFFFFFF, then write 0x00000000 with strb=4'b0101 -> read returns 0xFF00FF00 (DW=32).
REQ-030 Out of range: AW at BASE+N_WORDS*BPW, len=1 -> B SLVERR and memory unchanged; AR there -> 2 beats, data 0, SLVERR.
REQ-031 Protocol errors: early w.last on beat 1 of len=3 -> B SLVERR; a WRAP burst -> SLVERR with no write; atop != 0 -> SLVERR.
REQ-032 Reset mid-read-burst (beat 1 of len=3) -> r_valid = 0 immediately; after release, ar_ready = 1 and previously written data is intact.
